// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronised, debounced push-button producing single-cycle command pulses with long-press and auto-repeat
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 12500000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse,
    output logic level,
    output logic held
);
    localparam int MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DB_PRESS, DOWN, HOLD, DB_REL} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q;
    logic          pulse_q, pulse_d;
    logic          level_q, level_d;
    logic          held_q, held_d;

    assign pulse = pulse_q;
    assign level = level_q;
    assign held  = held_q;

    // two-flop synchroniser for the asynchronous button pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // state, shared counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            held_q  <= held_d;
        end
    end

    // debounce, long-press and repeat decisions; counter restarts on every transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        pulse_d = 1'b0;
        level_d = level_q;
        held_d  = held_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sync2_q) state_d = DB_PRESS;
            end
            DB_PRESS: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end
            end
            DOWN: begin
                if (!sync2_q) begin
                    state_d = DB_REL;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    held_d  = 1'b1;
                    pulse_d = REPEAT_EN;
                end
            end
            HOLD: begin
                if (!sync2_q) begin
                    state_d = DB_REL;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d   = '0;
                    pulse_d = REPEAT_EN;
                end
            end
            DB_REL: begin
                if (sync2_q) begin
                    state_d = held_q ? HOLD : DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    held_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule
